// File: rtl/add_sub_4bit_core.sv
// 4-bit registered adder/subtractor built from a ripple chain of full adders.
// Subtraction is x + ~y + 1: y is inverted per bit and the select feeds carry-in.
module add_sub_4bit_core (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       add_sub_select,
  output logic [3:0] z,
  output logic       carry_out,
  output logic       overflow
);

  logic [3:0] b_eff;
  logic [3:0] sum;
  logic [4:0] carry;

  logic [3:0] z_d, z_q;
  logic       carry_out_d, carry_out_q;
  logic       overflow_d, overflow_q;

  assign carry[0] = add_sub_select;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign b_eff[i]   = y[i] ^ add_sub_select;
    assign sum[i]     = x[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (x[i] & b_eff[i]) | (carry[i] & (x[i] ^ b_eff[i]));
  end

  always_comb begin
    z_d         = sum;
    carry_out_d = carry[4];
    // Signed overflow: carry into the sign bit disagrees with carry out of it.
    overflow_d  = carry[3] ^ carry[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= 4'b0000;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      z_q         <= z_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign z         = z_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_add_sub_4bit_core.sv
// Directed and exhaustive checks for add_sub_4bit_core: vectors, latency, async reset.
module tb_add_sub_4bit_core;

  logic       clk;
  logic       rst_n;
  logic [3:0] x;
  logic [3:0] y;
  logic       add_sub_select;
  logic [3:0] z;
  logic       carry_out;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  add_sub_4bit_core dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .x              (x),
    .y              (y),
    .add_sub_select (add_sub_select),
    .z              (z),
    .carry_out      (carry_out),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       sel;
    logic [3:0] z;
    logic       c;
    logic       ov;
  } vec_t;

  vec_t vecs [8];

  // Packs {z, carry_out, overflow}; compared as one 6-bit word.
  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got z=%b c=%b ov=%b, expected z=%b c=%b ov=%b",
               name, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic sel);
    int unsigned s;
    int          sa, sb, r;
    logic [5:0]  res;
    s  = sel ? (int'(a) + (15 - int'(b)) + 1) : (int'(a) + int'(b));
    sa = (a >= 8) ? int'(a) - 16 : int'(a);
    sb = (b >= 8) ? int'(b) - 16 : int'(b);
    r  = sel ? sa - sb : sa + sb;
    res[5:2] = s[3:0];
    res[1]   = s[4];
    res[0]   = (r > 7) || (r < -8);
    return res;
  endfunction

  function automatic logic [5:0] outs();
    return {z, carry_out, overflow};
  endfunction

  logic [5:0] prev_exp;
  logic [5:0] exp_w;

  initial begin
    vecs[0] = '{4'b1001, 4'b1010, 1'b0, 4'b0011, 1'b1, 1'b1};
    vecs[1] = '{4'b0111, 4'b0100, 1'b0, 4'b1011, 1'b0, 1'b1};
    vecs[2] = '{4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0};
    vecs[3] = '{4'b1010, 4'b1111, 1'b1, 4'b1011, 1'b0, 1'b0};
    vecs[4] = '{4'b1001, 4'b1001, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[5] = '{4'b0101, 4'b1010, 1'b0, 4'b1111, 1'b0, 1'b0};
    vecs[6] = '{4'b0011, 4'b1100, 1'b1, 4'b0111, 1'b0, 1'b0};
    vecs[7] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1};

    rst_n = 1'b0;
    x = 4'd0;
    y = 4'd0;
    add_sub_select = 1'b0;
    #2;
    check("reset_initial", outs(), 6'b000000);

    // Reset must hold outputs at zero through clock edges.
    x = 4'b1111;
    y = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_over_edge", outs(), 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", outs(), 6'b000000);

    // Back-to-back directed vectors: new operands every cycle.
    prev_exp = 6'b000000;
    for (int i = 0; i < 8; i++) begin
      x = vecs[i].x;
      y = vecs[i].y;
      add_sub_select = vecs[i].sel;
      #1;
      check($sformatf("vec%0d_hold_before_edge", i), outs(), prev_exp);
      @(posedge clk);
      #1;
      prev_exp = {vecs[i].z, vecs[i].c, vecs[i].ov};
      check($sformatf("vec%0d_result", i), outs(), prev_exp);
    end

    // Mid-stream reset discards a pending result and clears outputs at once.
    x = 4'b0111;
    y = 4'b0111;
    add_sub_select = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midstream_reset_immediate", outs(), 6'b000000);
    @(posedge clk);
    #1;
    check("midstream_reset_discard", outs(), 6'b000000);
    @(negedge clk);
    rst_n = 1'b1;
    x = 4'b0110;
    y = 4'b0011;
    add_sub_select = 1'b1;
    #1;
    check("post_reset_before_first_edge", outs(), 6'b000000);
    @(posedge clk);
    #1;
    check("post_reset_first_result", outs(), {4'b0011, 1'b1, 1'b0});

    // Exhaustive sweep, one operation per cycle.
    for (int k = 0; k < 512; k++) begin
      x = k[3:0];
      y = k[7:4];
      add_sub_select = k[8];
      exp_w = model(k[3:0], k[7:4], k[8]);
      @(posedge clk);
      #1;
      check($sformatf("sweep_x%0d_y%0d_s%0d", k[3:0], k[7:4], k[8]), outs(), exp_w);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
